// File: rtl/bsr_layer_sequencer_if.sv
// rtl/bsr_layer_sequencer_if.sv - scheduler and output-drain handshake bundle
// master is the layer sequencer; slave is the scheduler/PE/drain side.
interface bsr_layer_sequencer_if #(
  parameter int K_W = 12
) ();
  logic           sched_start;
  logic           sched_abort;
  logic [K_W-1:0] sched_KT;
  logic           sched_done;
  logic           pe_clr;
  logic           drain_req;
  logic           drain_ack;

  modport master (
    output sched_start, sched_abort, sched_KT, pe_clr, drain_req,
    input  sched_done, drain_ack
  );

  modport slave (
    input  sched_start, sched_abort, sched_KT, pe_clr, drain_req,
    output sched_done, drain_ack
  );
endinterface

// File: rtl/bsr_layer_sequencer.sv
// rtl/bsr_layer_sequencer.sv - layer controller running one BSR pass per M tile
// Clear, launch, wait, drain per tile; watchdog, abort fan-out and perf counters.
module bsr_layer_sequencer #(
  parameter int M_W    = 10,
  parameter int K_W    = 12,
  parameter int WDOG_W = 20,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [M_W-1:0]        cfg_MT,
  input  logic [K_W-1:0]        cfg_KT,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [M_W-1:0]        m_tile,
  output logic [CNT_W-1:0]      cyc_count,
  output logic [CNT_W-1:0]      tile_count,
  bsr_layer_sequencer_if.master sched
);

  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    CLEAR  = 7'b0000010,
    LAUNCH = 7'b0000100,
    RUN    = 7'b0001000,
    DRAIN  = 7'b0010000,
    NEXT   = 7'b0100000,
    ERR    = 7'b1000000
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  state_t            state;
  logic [M_W-1:0]    mt;
  logic [K_W-1:0]    kt;
  logic [WDOG_W-1:0] wdog;
  logic              sched_start_q;
  logic              sched_abort_q;
  logic              pe_clr_q;
  logic              drain_req_q;

  assign sched.sched_start = sched_start_q;
  assign sched.sched_abort = sched_abort_q;
  assign sched.sched_KT    = kt;
  assign sched.pe_clr      = pe_clr_q;
  assign sched.drain_req   = drain_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_tile        <= '0;
      cyc_count     <= '0;
      tile_count    <= '0;
      mt            <= '0;
      kt            <= '0;
      wdog          <= '0;
      sched_start_q <= 1'b0;
      sched_abort_q <= 1'b0;
      pe_clr_q      <= 1'b0;
      drain_req_q   <= 1'b0;
    end else begin
      done          <= 1'b0;
      sched_start_q <= 1'b0;
      sched_abort_q <= 1'b0;
      pe_clr_q      <= 1'b0;
      if (busy && !(&cyc_count)) cyc_count <= cyc_count + 1'b1;

      // Abort on an active layer overrides every same-cycle event below.
      if (cfg_abort && state != IDLE && state != ERR) begin
        state         <= IDLE;
        sched_abort_q <= 1'b1;
        busy          <= 1'b0;
        drain_req_q   <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: begin
            if (cfg_abort) begin
              state <= IDLE;
            end else if (cfg_start) begin
              cyc_count  <= '0;
              tile_count <= '0;
              if (cfg_MT != '0 && cfg_KT != '0) begin
                mt       <= cfg_MT;
                kt       <= cfg_KT;
                m_tile   <= '0;
                error    <= 1'b0;
                busy     <= 1'b1;
                pe_clr_q <= 1'b1;
                state    <= CLEAR;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
          CLEAR: begin
            sched_start_q <= 1'b1;
            state         <= LAUNCH;
          end
          LAUNCH: begin
            wdog  <= '0;
            state <= RUN;
          end
          RUN: begin
            if (sched.sched_done) begin
              drain_req_q <= 1'b1;
              state       <= DRAIN;
            end else begin
              wdog <= wdog + 1'b1;
              if (wdog == WDOG_MAX - 1'b1) begin
                error         <= 1'b1;
                sched_abort_q <= 1'b1;
                busy          <= 1'b0;
                state         <= ERR;
              end
            end
          end
          DRAIN: begin
            if (sched.drain_ack) begin
              drain_req_q <= 1'b0;
              state       <= NEXT;
            end
          end
          NEXT: begin
            if (!(&tile_count)) tile_count <= tile_count + 1'b1;
            // mt is nonzero whenever a layer is active, so mt-1 cannot wrap.
            if (m_tile == mt - 1'b1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              m_tile   <= m_tile + 1'b1;
              pe_clr_q <= 1'b1;
              state    <= CLEAR;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bsr_layer_sequencer.sv
// tb/tb_bsr_layer_sequencer.sv - directed self-checking bench for bsr_layer_sequencer
module tb_bsr_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [9:0]  mt_in;
  logic [11:0] kt_in;
  logic        busy, done, error;
  logic [9:0]  m_tile;
  logic [31:0] cyc, tiles;

  logic        w_start, w_abort;
  logic [9:0]  w_mt;
  logic [11:0] w_kt;
  logic        w_busy, w_done_o, w_error;
  logic [9:0]  w_m_tile;
  logic [31:0] w_cyc, w_tiles;
  logic        w_sd, w_ack;

  logic        sd_resp, ack_resp, sd_extra;
  int          sd_delay, ack_delay, sd_cnt, ack_cnt;
  bit          ack_arm;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  bsr_layer_sequencer_if #(.K_W(12)) sif ();
  bsr_layer_sequencer_if #(.K_W(12)) wif ();

  assign sif.sched_done = sd_resp | sd_extra;
  assign sif.drain_ack  = ack_resp;
  assign wif.sched_done = w_sd;
  assign wif.drain_ack  = w_ack;

  bsr_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(start), .cfg_abort(abort),
    .cfg_MT(mt_in), .cfg_KT(kt_in), .busy(busy), .done(done), .error(error),
    .m_tile(m_tile), .cyc_count(cyc), .tile_count(tiles), .sched(sif)
  );

  bsr_layer_sequencer #(.WDOG_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .cfg_start(w_start), .cfg_abort(w_abort),
    .cfg_MT(w_mt), .cfg_KT(w_kt), .busy(w_busy), .done(w_done_o), .error(w_error),
    .m_tile(w_m_tile), .cyc_count(w_cyc), .tile_count(w_tiles), .sched(wif)
  );

  // Scheduler / drain responder: sched_done sd_delay cycles after sched_start,
  // drain_ack ack_delay cycles after drain_req rises.
  always @(negedge clk) begin
    sd_resp  = 1'b0;
    ack_resp = 1'b0;
    if (!rst_n || sif.sched_abort) begin
      sd_cnt  = 0;
      ack_arm = 1'b0;
    end else begin
      if (sif.sched_start) sd_cnt = sd_delay;
      else if (sd_cnt > 0) begin
        sd_cnt--;
        if (sd_cnt == 0) sd_resp = 1'b1;
      end
      if (sif.drain_req) begin
        if (!ack_arm) begin
          ack_arm = 1'b1;
          ack_cnt = ack_delay;
        end else if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) ack_resp = 1'b1;
        end
      end else ack_arm = 1'b0;
    end
  end

  task automatic start_main(input logic [9:0] mt, input logic [11:0] kt);
    @(negedge clk);
    start = 1'b1; mt_in = mt; kt_in = kt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; mt_in = 0; kt_in = 0; sd_extra = 0;
    w_start = 0; w_abort = 0; w_mt = 0; w_kt = 0; w_sd = 0; w_ack = 0;
    sd_delay = 20; ack_delay = 2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, error}); end
    total++; if ({sif.sched_start, sif.sched_abort, sif.pe_clr, sif.drain_req} !== 4'b0000) begin bad++; $display("FAIL reset_sched got=%b exp=0000", {sif.sched_start, sif.sched_abort, sif.pe_clr, sif.drain_req}); end
    total++; if (m_tile !== 10'd0 || sif.sched_KT !== 12'd0) begin bad++; $display("FAIL reset_regs m_tile=%0d kt=%0d exp=0", m_tile, sif.sched_KT); end
    total++; if (cyc !== 32'd0 || tiles !== 32'd0) begin bad++; $display("FAIL reset_counters cyc=%0d tiles=%0d exp=0", cyc, tiles); end
  endtask

  task automatic test_full_layer();
    int pe_n, ss_n, mt_err;
    bit seen;
    sd_delay = 20; ack_delay = 2;
    start_main(10'd3, 12'd2);
    total++; if (sif.pe_clr !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL full_cycle1 pe_clr=%b busy=%b exp=11", sif.pe_clr, busy); end
    pe_n = 0; ss_n = 0; mt_err = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (sif.pe_clr) begin
        if (m_tile !== 10'(pe_n)) mt_err++;
        pe_n++;
      end
      if (sif.sched_start) ss_n++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL full_done_timeout got=0 exp=1"); end
    total++; if (pe_n != 3 || ss_n != 3) begin bad++; $display("FAIL full_pulses pe_clr=%0d sched_start=%0d exp=3,3", pe_n, ss_n); end
    total++; if (mt_err != 0 || m_tile !== 10'd2) begin bad++; $display("FAIL full_m_tile errs=%0d final=%0d exp=0,2", mt_err, m_tile); end
    total++; if (tiles !== 32'd3) begin bad++; $display("FAIL full_tile_count got=%0d exp=3", tiles); end
    total++; if (cyc !== 32'd78) begin bad++; $display("FAIL full_cyc_count got=%0d exp=78", cyc); end
    total++; if (busy !== 1'b0 || sif.sched_KT !== 12'd2) begin bad++; $display("FAIL full_end busy=%b kt=%0d exp=0,2", busy, sif.sched_KT); end
    @(negedge clk);
    total++; if (done !== 1'b0 || cyc !== 32'd78) begin bad++; $display("FAIL full_single_done done=%b cyc=%0d exp=0,78", done, cyc); end
  endtask

  task automatic test_zero_mt();
    int extra;
    start_main(10'd0, 12'd5);
    total++; if (done !== 1'b1 || busy !== 1'b0 || sif.sched_start !== 1'b0) begin bad++; $display("FAIL zero_done done=%b busy=%b ss=%b exp=100", done, busy, sif.sched_start); end
    total++; if (cyc !== 32'd0 || tiles !== 32'd0) begin bad++; $display("FAIL zero_counters cyc=%0d tiles=%0d exp=0", cyc, tiles); end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || sif.sched_start || sif.pe_clr) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL zero_idle got=%0d exp=0", extra); end
  endtask

  task automatic test_abort();
    int ss_n, extra;
    sd_delay = 20; ack_delay = 2;
    start_main(10'd2, 12'd1);
    ss_n = 0;
    for (int i = 0; i < 200 && ss_n < 2; i++) begin
      if (sif.sched_start) ss_n++;
      if (ss_n < 2) @(negedge clk);
    end
    total++; if (ss_n != 2) begin bad++; $display("FAIL abort_tile1_timeout got=%0d exp=2", ss_n); end
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0 || sif.sched_abort !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL abort_take busy=%b sabort=%b done=%b exp=010", busy, sif.sched_abort, done); end
    total++; if (tiles !== 32'd1 || cyc !== 32'd33 || m_tile !== 10'd1) begin bad++; $display("FAIL abort_counters tiles=%0d cyc=%0d m_tile=%0d exp=1,33,1", tiles, cyc, m_tile); end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || sif.sched_abort || sif.sched_start || cyc !== 32'd33) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL abort_hold got=%0d exp=0", extra); end
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    w_start = 1'b1; w_mt = 10'd1; w_kt = 12'd1;
    @(negedge clk);
    w_start = 1'b0;
    repeat (16) @(negedge clk);
    total++; if (w_busy !== 1'b1 || w_error !== 1'b0) begin bad++; $display("FAIL wdog_last_run busy=%b error=%b exp=10", w_busy, w_error); end
    @(negedge clk);
    total++; if (w_error !== 1'b1 || wif.sched_abort !== 1'b1 || w_busy !== 1'b0) begin bad++; $display("FAIL wdog_err error=%b sabort=%b busy=%b exp=110", w_error, wif.sched_abort, w_busy); end
    @(negedge clk);
    total++; if (w_error !== 1'b1 || wif.sched_abort !== 1'b0) begin bad++; $display("FAIL wdog_sticky error=%b sabort=%b exp=10", w_error, wif.sched_abort); end
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    total++; if (w_error !== 1'b0 || wif.pe_clr !== 1'b1) begin bad++; $display("FAIL wdog_restart error=%b pe_clr=%b exp=01", w_error, wif.pe_clr); end
    @(negedge clk);
    @(negedge clk);
    w_sd = 1'b1;
    @(negedge clk);
    w_sd = 1'b0;
    total++; if (wif.drain_req !== 1'b1) begin bad++; $display("FAIL wdog_drain got=%b exp=1", wif.drain_req); end
    w_ack = 1'b1;
    @(negedge clk);
    w_ack = 1'b0;
    @(negedge clk);
    total++; if (w_done_o !== 1'b1 || w_tiles !== 32'd1 || w_error !== 1'b0) begin bad++; $display("FAIL wdog_complete done=%b tiles=%0d error=%b exp=1,1,0", w_done_o, w_tiles, w_error); end
  endtask

  task automatic test_drain_stall();
    bit found;
    int hold;
    sd_delay = 5; ack_delay = 50;
    start_main(10'd1, 12'd3);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (sif.drain_req) found = 1;
      else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL stall_req_timeout got=0 exp=1"); end
    hold = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 10) sd_extra = 1'b1;
      if (i == 11) sd_extra = 1'b0;
      if (sif.drain_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) hold++;
    end
    total++; if (hold != 0) begin bad++; $display("FAIL stall_hold drops=%0d exp=0", hold); end
    @(negedge clk);
    total++; if (sif.drain_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_release req=%b busy=%b exp=01", sif.drain_req, busy); end
    @(negedge clk);
    total++; if (done !== 1'b1 || tiles !== 32'd1) begin bad++; $display("FAIL stall_done done=%b tiles=%0d exp=1,1", done, tiles); end
  endtask

  task automatic test_start_abort();
    sd_delay = 20; ack_delay = 2;
    start_main(10'd2, 12'd2);
    repeat (4) @(negedge clk);
    start = 1'b1; abort = 1'b1; mt_in = 10'd5; kt_in = 12'd7;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || sif.sched_abort !== 1'b1 || sif.sched_KT !== 12'd2) begin bad++; $display("FAIL both_abort busy=%b sabort=%b kt=%0d exp=0,1,2", busy, sif.sched_abort, sif.sched_KT); end
    @(negedge clk);
    total++; if (sif.pe_clr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL both_start_ignored pe_clr=%b busy=%b done=%b exp=000", sif.pe_clr, busy, done); end
  endtask

  task automatic test_reset_mid_drain();
    bit found;
    sd_delay = 3; ack_delay = 50;
    start_main(10'd1, 12'd1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (sif.drain_req) found = 1;
      else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL rst_req_timeout got=0 exp=1"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, error, sif.drain_req, sif.sched_abort} !== 5'b0) begin bad++; $display("FAIL rst_async_flags got=%b exp=00000", {busy, done, error, sif.drain_req, sif.sched_abort}); end
    total++; if (cyc !== 32'd0 || sif.sched_KT !== 12'd0) begin bad++; $display("FAIL rst_async_regs cyc=%0d kt=%0d exp=0", cyc, sif.sched_KT); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_no_done done=%b busy=%b exp=00", done, busy); end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_zero_mt();
    test_abort();
    test_watchdog();
    test_drain_stall();
    test_start_abort();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsr_layer_sequencer.md
Name: bsr_layer_sequencer

Overview:
- Layer-level controller above the BSR sparse scheduler.
- Runs one full BSR pass per M tile for MT tiles:
  - clears PE accumulators,
  - launches the scheduler,
  - waits for its done,
  - hands the finished 14×14 output tile to the output drain path via req/ack.
- Provides layer-level busy/done/error, abort fan-out, a watchdog and performance counters for the CSR block.

Parameters:
- M_W, 10, width of M tile count and index.
- K_W, 12, width of K tile count.
- WDOG_W, 20, watchdog width; RUN timeout is 2^WDOG_W-1 cycles.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  start layer; sampled only in IDLE
- cfg_abort  in  1  abort layer; highest priority
- cfg_MT  in  M_W  M tile count; latched on accepted start
- cfg_KT  in  K_W  K tile count; latched on accepted start
- busy  out  1  high from CLEAR through NEXT
- done  out  1  1-cycle pulse on layer completion
- error  out  1  sticky watchdog error
- m_tile  out  M_W  current M tile index
- sched_start  out  1  1-cycle start to scheduler
- sched_abort  out  1  1-cycle abort to scheduler
- sched_KT  out  K_W  latched KT driven to scheduler
- sched_done  in  1  scheduler done pulse
- pe_clr  out  1  1-cycle PE accumulator clear
- drain_req  out  1  output tile ready for drain
- drain_ack  in  1  drain path accepted tile
- cyc_count  out  CNT_W  cycles spent busy in the current/last layer
- tile_count  out  CNT_W  tiles completed in the current/last layer

Behaviour:
- Reset values:
  - state IDLE.
  - busy, done, error, sched_start, sched_abort, pe_clr, drain_req = 0.
  - m_tile, sched_KT, cyc_count, tile_count = 0.
  - Latched MT = 0; watchdog = 0.
- FSM, one-hot: IDLE, CLEAR, LAUNCH, RUN, DRAIN, NEXT, ERR. All outputs are registered.
- pe_clr, sched_start and drain_req are high exactly while in CLEAR, LAUNCH and DRAIN respectively.
- IDLE:
  - cfg_start with cfg_MT!=0 and cfg_KT!=0: latch MT/KT, m_tile=0, clear cyc_count, tile_count and error, go to CLEAR.
  - cfg_start with MT==0 or KT==0: done pulses the next cycle, state stays IDLE, counters are cleared.
- Latency: start sampled at edge 0 → pe_clr high in cycle 1 → sched_start high in cycle 2 → RUN from cycle 3.
- CLEAR → LAUNCH unconditionally (1 cycle).
- LAUNCH → RUN unconditionally (1 cycle); watchdog cleared.
- RUN:
  - Watchdog increments each cycle.
  - sched_done high → DRAIN.
  - Watchdog reaching 2^WDOG_W-1 without sched_done → ERR.
  - sched_done is ignored in every state except RUN.
- DRAIN:
  - drain_req held high until drain_ack is sampled high.
  - On ack: go to NEXT; drain_req is low in the following cycle.
  - drain_ack while drain_req is low is ignored.
- NEXT (1 cycle):
  - tile_count += 1.
  - If m_tile == MT-1: done pulses the next cycle and state goes to IDLE; m_tile holds at MT-1.
  - Else: m_tile += 1 and state goes to CLEAR.
- ERR:
  - On entry: error=1 (sticky), sched_abort pulses 1 cycle, busy=0.
  - Stays in ERR until cfg_start; cfg_start is treated exactly as in IDLE and clears error.
  - cfg_abort in ERR returns to IDLE without clearing error.
- cfg_abort in any state other than IDLE/ERR:
  - Next state is IDLE; sched_abort pulses 1 cycle; busy=0; drain_req=0.
  - No done pulse; counters hold.
  - Abort wins over a same-cycle sched_done, drain_ack or NEXT completion.
- cfg_start while not in IDLE/ERR is ignored.
- cyc_count:
  - Increments every cycle busy is high; saturates at all-ones.
  - Holds after done or abort until the next accepted start.
- tile_count saturates at all-ones; it cannot practically saturate given M_W < CNT_W.
- Width rule: the MT-1 comparison uses M_W arithmetic on a nonzero latched MT, so there is no underflow.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; no done pulse; the scheduler is reset by the same rst_n.

Test Plan:
- MT=3, KT=2; sched_done 20 cycles after each sched_start; drain_ack 2 cycles after drain_req → 3 pe_clr pulses, 3 sched_start pulses, m_tile 0→1→2, tile_count=3, single done pulse, busy low after done.
- cfg_start with MT=0, KT=5 → done pulses 1 cycle after start, busy never high, sched_start never high.
- MT=2, KT=1; cfg_abort in RUN of tile 1 → IDLE next cycle, sched_abort 1-cycle pulse, no done, tile_count=1.
- WDOG_W=4; sched_done never arrives → ERR after 15 RUN cycles, error=1, sched_abort pulse; a following cfg_start with MT=1 clears error and completes normally.
- drain_ack held low 50 cycles, then 1-cycle pulse → drain_req stays high throughout and drops the cycle after ack; a sched_done injected during DRAIN is ignored.
- cfg_start and cfg_abort issued mid-layer in the same cycle → start ignored, abort taken. rst_n asserted mid-DRAIN → all outputs at reset values immediately.
